// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and address-check helpers
// for the data-memory responder.
package dmem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  // Misaligned, or any bit set above the word index.
  function automatic logic addr_err(
    input logic [31:0] addr,
    input int          depth
  );
    logic [31:0] hi;
    hi = addr >> (idx_w(depth) + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with byte-enabled write,
// asynchronous read and synchronous clear.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem[ridx_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready load/store target with
// fixed wait states in front of a word array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int IDX_W = idx_w(DEPTH_WORDS);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;

  logic             accept;
  logic             commit;
  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic             cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      rd_word;

  assign accept = (state == IDLE) && req_valid_i;

  // With no wait states the commit lands on the
  // accept edge, so it must see the live request.
  assign cur_we    = (state == IDLE) ? req_we_i    : we_q;
  assign cur_addr  = (state == IDLE) ? req_addr_i  : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata_i : wdata_q;
  assign cur_be    = (state == IDLE) ? req_be_i    : be_q;
  assign cur_err   = addr_err(cur_addr, DEPTH_WORDS);
  assign cur_idx   = cur_addr[IDX_W+1:2];

  assign commit = (WAIT_CYCLES == 0) ? accept
                : ((state == WAIT) && (cnt == '0));

  assign req_ready_o = (state == IDLE) && rst_i;
  assign rsp_valid_o = (state == RESP);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (commit && cur_we && !cur_err),
    .widx_i (cur_idx),
    .wdata_i(cur_wdata),
    .be_i   (cur_be),
    .ridx_i (cur_idx),
    .rdata_o(rd_word)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (commit) begin
        rsp_err_o   <= cur_err;
        rsp_rdata_o <= (cur_we || cur_err) ? '0 : rd_word;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed transactions
// checked against a cycle-level behavioural model.
module tb_dmem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_valid, z_ready, z_we;
  logic [31:0] z_addr, z_wdata;
  logic [3:0]  z_be;
  logic        z_rvalid, z_rready, z_err;
  logic [31:0] z_rdata;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(z_valid), .req_ready_o(z_ready),
    .req_we_i(z_we), .req_addr_i(z_addr),
    .req_wdata_i(z_wdata), .req_be_i(z_be),
    .rsp_valid_o(z_rvalid), .rsp_ready_i(z_rready),
    .rsp_rdata_o(z_rdata), .rsp_err_o(z_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: an accept in cycle c yields a response
  // visible in cycle c+W+1, committed on that edge.
  int          cyc = 0;
  bit          pend = 0, resp = 0;
  int          due;
  bit          p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  logic [31:0] e_rdata;
  bit          e_err;
  logic [31:0] mm [DEPTH];

  always @(posedge clk) begin
    if (!rst) begin
      foreach (mm[i]) mm[i] = '0;
      pend = 0;
      resp = 0;
    end else begin
      if (resp) begin
        if (rsp_ready) resp = 0;
      end else if (!pend && req_valid) begin
        pend = 1; due = cyc + W + 1;
        p_we = req_we; p_addr = req_addr;
        p_wdata = req_wdata; p_be = req_be;
      end
      if (pend && cyc + 1 == due) begin
        pend = 0; resp = 1;
        e_err = (p_addr % 4 != 0) || (p_addr >= DEPTH * 4);
        e_rdata = '0;
        if (p_we) begin
          if (!e_err)
            for (int b = 0; b < 4; b++)
              if (p_be[b]) mm[p_addr/4][8*b +: 8] = p_wdata[8*b +: 8];
        end else if (!e_err) begin
          e_rdata = mm[p_addr/4];
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", req_ready, rst && !pend && !resp);
      chk("rsp_valid", rsp_valid, resp);
      if (resp) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", rsp_err, e_err);
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic start(input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    req_valid = 1; req_we = we; req_addr = a;
    req_wdata = wd; req_be = be;
  endtask

  task automatic wait_acc(output int ac);
    int n = 0;
    while (!req_ready && n < 60) begin step(); n++; end
    if (n >= 60) chk("acc_timeout", 0, 1);
    ac = cyc;
    step();
    req_valid = 0;
  endtask

  task automatic wait_rsp(input int bp, input int ac,
                          output logic [31:0] rd, output bit er,
                          output int lat);
    int n = 0;
    while (!rsp_valid && n < 60) begin step(); n++; end
    if (n >= 60) chk("rsp_timeout", 0, 1);
    lat = cyc - ac; rd = rsp_rdata; er = rsp_err;
    repeat (bp) step();
    rsp_ready = 1;
    step();
  endtask

  task automatic txn(input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int bp, output logic [31:0] rd,
                     output bit er, output int lat);
    int ac;
    start(we, a, wd, be);
    if (bp > 0) rsp_ready = 0;
    wait_acc(ac);
    wait_rsp(bp, ac, rd, er, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    bit er;
    int lat, ac, acc, r;
    rst = 0; req_valid = 0; req_we = 0; req_addr = 0;
    req_wdata = 0; req_be = 0; rsp_ready = 1;
    z_valid = 0; z_we = 0; z_addr = 0; z_wdata = 0;
    z_be = 0; z_rready = 1;
    repeat (3) step();
    chk("rst_req_ready", req_ready, 0);
    rst = 1;
    #1;
    chk("rst_ready_up", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk_on = 1;

    txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    chk("w10_lat", lat, 3);
    chk("w10_rdata", rd, 0);
    chk("w10_err", er, 0);
    txn(0, 32'h10, 0, 4'h0, 0, rd, er, lat);
    chk("r10_rdata", rd, 32'hDEADBEEF);
    txn(1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
    txn(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
    txn(0, 32'h20, 0, 4'hF, 0, rd, er, lat);
    chk("r20_merge", rd, 32'h11BB33DD);
    txn(0, 32'h22, 0, 4'hF, 0, rd, er, lat);
    chk("r22_err", er, 1);
    chk("r22_rdata", rd, 0);
    txn(0, 32'h400, 0, 4'hF, 0, rd, er, lat);
    chk("r400_err", er, 1);
    chk("r400_rdata", rd, 0);
    txn(1, 32'h400, 32'h55555555, 4'hF, 0, rd, er, lat);
    chk("w400_err", er, 1);
    txn(0, 32'h0, 0, 4'hF, 0, rd, er, lat);
    chk("r0_after_w400", rd, 0);
    txn(1, 32'h30, 32'h12345678, 4'h0, 0, rd, er, lat);
    chk("be0_err", er, 0);
    txn(0, 32'h30, 0, 4'hF, 0, rd, er, lat);
    chk("be0_nochange", rd, 0);

    // Backpressure with a second request held behind it.
    start(0, 32'h10, 0, 4'hF);
    rsp_ready = 0;
    wait_acc(ac);
    start(0, 32'h20, 0, 4'hF);
    r = 0;
    while (!rsp_valid && r < 60) begin step(); r++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_err", rsp_err, 0);
      chk("bp_req_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1;
    step();
    chk("bp_ready_after", req_ready, 1);
    wait_acc(ac);
    wait_rsp(0, ac, rd, er, lat);
    chk("bp_next_rdata", rd, 32'h11BB33DD);
    chk("bp_next_lat", lat, 3);

    // Reset while the write sits in WAIT.
    start(1, 32'h8, 32'hCAFEF00D, 4'hF);
    wait_acc(ac);
    rst = 0;
    step(); step();
    rst = 1;
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_rsp", rsp_valid, 0);
      step();
    end
    txn(0, 32'h8, 0, 4'hF, 0, rd, er, lat);
    chk("r8_after_rst", rd, 0);
    txn(0, 32'h10, 0, 4'hF, 0, rd, er, lat);
    chk("r10_after_rst", rd, 0);

    // Zero wait states: one accept every two cycles.
    z_valid = 1; z_we = 1; z_addr = 32'h4;
    z_wdata = 32'h12345678; z_be = 4'hF;
    chk("z_ready0", z_ready, 1);
    step();
    chk("z_wvalid", z_rvalid, 1);
    chk("z_werr", z_err, 0);
    z_we = 0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (z_ready) acc++;
      else chk("z_rdata", z_rdata, 32'h12345678);
      chk("z_alt", z_rvalid, !z_ready);
    end
    z_valid = 0;
    chk("z_accepts", acc, 5);

    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 15)) << 2)
                           | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'h400 + (32'($urandom_range(0, 15)) << 2);
      else             a = $urandom;
      txn($urandom_range(0, 1) == 1, a, $urandom,
          4'($urandom_range(0, 15)), $urandom_range(0, 2),
          rd, er, lat);
      chk("rand_lat", lat, W + 1);
    end

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
